div_iter: RTL

//  Iterative radix-2 restoring divider: responder side of the EX-stage divide handshake (start_i/ready_o).
//  EX holds start_i high with operands stable while stalled, then drops start_i once ready_o is seen.

---
 rtl/div_iter_pkg.sv | 14 +
 rtl/div_iter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/div_iter_pkg.sv
// Shared encodings for the iterative divider: FSM states and result-ready levels.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider answering the EX-stage start_i/ready_o handshake.
// Handshake: start_i is held with stable operands until ready_o=1; result_o is valid while ready_o=1.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic [1:0]            dbg_state_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;
    logic                signed_q, signed_d;
    logic                ready_q, ready_d;
    logic [2*DATA_W-1:0] result_q, result_d;

    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_abs, op2_abs;
    logic [DATA_W:0]     shifted, trial;
    logic                qbit;
    logic [DATA_W-1:0]   rem_next, quot_next, rem_fix, quot_fix;

    // Magnitudes; the most negative value maps onto itself and is then read as unsigned.
    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    // One restoring step: quotient bits shift into the dividend register from the bottom.
    assign shifted   = {rem_q, dvd_q[DATA_W-1]};
    assign trial     = shifted - {1'b0, divisor_q};
    assign qbit      = (shifted >= {1'b0, divisor_q});
    assign rem_next  = qbit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    assign quot_next = {dvd_q[DATA_W-2:0], qbit};
    assign quot_fix  = (signed_q & neg_quot_q) ? (~quot_next + 1'b1) : quot_next;
    assign rem_fix   = (signed_q & neg_rem_q)  ? (~rem_next + 1'b1)  : rem_next;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        signed_d   = signed_q;
        ready_d    = ready_q;
        result_d   = result_q;

        case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        dvd_d      = op1_abs;
                        divisor_d  = op2_abs;
                        neg_quot_d = op1_neg ^ op2_neg;
                        neg_rem_d  = op1_neg;
                        signed_d   = signed_div_i;
                        rem_d      = '0;
                        cnt_d      = '0;
                        state_d    = DIV_ON;
                    end
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d  = DIV_END;
                    result_d = '0;
                    ready_d  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else begin
                    rem_d = rem_next;
                    dvd_d = quot_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        result_d = {rem_fix, quot_fix};
                        ready_d  = DIV_RESULT_READY;
                        state_d  = DIV_END;
                    end
                end
            end
            DIV_END: begin
                if (!start_i || annul_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            signed_q   <= 1'b0;
            ready_q    <= DIV_RESULT_NOT_READY;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            signed_q   <= signed_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
        end
    end

    assign result_o    = result_q;
    assign ready_o     = ready_q;
    assign dbg_state_o = state_q;

endmodule
